mips32_fetch_queue: RTL and testbench
=====================================

// Module: mips32_fetch_queue
// PURPOSE
//  Instruction prefetch unit upstream of the IF/ID register of the pipelined MIPS32 core.
//  Issues word-addressed reads to instruction memory and buffers returned words in a small in-order queue.
//  Presents {IR, NPC} to the ID stage with a valid/ready handshake.
//  Handles taken-branch redirects from EX/MEM and a halt request.
// PARAMETERS
//  ADDR_W    10  instruction memory word-address width (1024-word Mem)
//  DEPTH     4   queue entries; also the cap on (occupancy + in-flight reads); power of 2, >=2
//  RESET_PC  0   fetch PC loaded at reset
// PORTS
//  clk1         in   1       clock; all state updates on posedge
//  rst_n        in   1       synchronous reset, active low
//  imem_req     out  1       read request valid
//  imem_addr    out  ADDR_W  read word address = pc[ADDR_W-1:0]
//  imem_gnt     in   1       request accepted this cycle (imem_req && imem_gnt)
//  imem_rvalid  in   1       read data valid; one per accepted request, in order, >=1 cycle later
//  imem_rdata   in   32      read data (instruction word)
//  redirect     in   1       taken branch: flush and refetch from redirect_pc
//  redirect_pc  in   32      branch target word address (EX_MEM_ALUOut)
//  halt         in   1       HLT retired: stop issuing fetches
//  out_valid    out  1       head entry valid
//  out_ir       out  32      head instruction word
//  out_npc      out  32      head fetch address + 1
//  out_taken    out  1       head is the first instruction fetched after a redirect
//  out_ready    in   1       ID stage accepts head this cycle
// BEHAVIOUR
//  - State: pc[31:0]; queue of DEPTH x {ir, npc, taken}; count; pend (in-flight reads, 0..DEPTH);
//    drop (stale in-flight reads, <= pend); FSM IDLE/RUN/HALTED.
//  - Reset (rst_n=0 at posedge):
//    * pc=RESET_PC, count=pend=drop=0, FSM=IDLE, mark_taken=0.
//    * Outputs imem_req=0, out_valid=0, out_ir=0, out_npc=0, out_taken=0.
//    * imem_rvalid is ignored while rst_n=0. The memory model must be reset together with this block.
//  - FSM:
//    * IDLE -> RUN after one cycle.
//    * RUN -> HALTED when halt=1.
//    * HALTED is sticky until rst_n=0.
//    * redirect in HALTED is ignored.
//  - imem_req = (FSM==RUN) && !halt && !redirect && (count + pend < DEPTH).
//    This is combinational on registered state and the halt/redirect inputs.
//  - Accepted request (imem_req && imem_gnt): pend+1, pc <= pc+1. pc is 32-bit and wraps mod 2^32.
//  - imem_addr truncates pc, so it wraps 2^ADDR_W-1 -> 0. npc is not truncated.
//  - Response (imem_rvalid):
//    * Always pend-1.
//    * If drop>0: drop-1 and discard the data.
//    * Else push {imem_rdata, addr+1, mark_taken}; addr is the word's own fetch address, tracked in order; clear mark_taken.
//  - Pop when out_valid && out_ready && !redirect. There is no bypass: data is visible at least 1 cycle after rvalid.
//  - Redirect (FSM==RUN, redirect=1) has priority over everything:
//    * Queue flushed (count=0); any same-cycle pop is void.
//    * pc <= redirect_pc; mark_taken <= 1.
//    * drop <= pend - rvalid, meaning every read still in flight after this cycle is stale.
//    * A same-cycle response is discarded.
//    * No request is issued in the redirect cycle.
//  - Full: the credit rule guarantees a push never meets a full queue.
//    Push and pop in the same cycle at count==DEPTH cannot occur; at other counts both happen, count unchanged.
//  - Empty: out_valid=0; out_ir/out_npc/out_taken hold their last value.
//  - halt: no new requests. In-flight responses are still accepted. The queue still drains to ID.
// TESTING
//  1. Reset; mem latency 1, gnt=1, ready=1.
//     -> out_ir = Mem[0],Mem[1],Mem[2]...; out_npc = 1,2,3...; out_taken=0.
//  2. ready=0 for 10 cycles.
//     -> exactly DEPTH(4) requests accepted, then imem_req=0.
//     -> On ready=1 all 4 words pop in order; no loss and no duplicates.
//  3. Latency 3 with 2 reads in flight; redirect, redirect_pc=0x20.
//     -> both stale words dropped.
//     -> next out_ir=Mem[0x20], out_npc=0x21, out_taken=1; following entry out_taken=0.
//  4. redirect, out_ready and imem_rvalid all in the same cycle.
//     -> head not consumed, response discarded, drop = pend-1, queue empty next cycle.
//  5. halt=1 with 3 queued and 1 in flight.
//     -> imem_req=0 from that cycle; all 4 words delivered.
//     -> FSM stays HALTED and redirect is ignored until rst_n=0.
//  6. redirect_pc=0x3FF.
//     -> imem_addr 0x3FF then 0x000.
//     -> out_npc 0x400 then 0x401.

Source files
------------

// File: rtl/mips32_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : mips32_fetch_queue
// Description : Instruction prefetch unit feeding the IF/ID register. Issues
//               word-addressed reads, buffers returned words in an in-order
//               queue and hands {IR, NPC, taken} to ID over valid/ready.
//               Branch redirects flush the queue and squash stale reads.
// Revision    : 1.0 - initial release
// ============================================================================
module mips32_fetch_queue #(
  parameter int          ADDR_W   = 10,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk1,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  output logic [31:0]       out_ir,
  output logic [31:0]       out_npc,
  output logic              out_taken,
  input  logic              out_ready
);

  localparam int             PTR_W      = $clog2(DEPTH);
  localparam int             CNT_W      = PTR_W + 1;
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [31:0]      pc;
  logic [31:0]      rsp_pc;      // fetch address of the next non-stale response
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] count_nx;
  logic [CNT_W-1:0] left_after_pop;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_nx;
  logic             mark_taken;

  logic [31:0]      q_ir    [DEPTH];
  logic [31:0]      q_npc   [DEPTH];
  logic             q_taken [DEPTH];

  logic             do_redirect;
  logic             accept;
  logic             push;
  logic             pop;
  logic [31:0]      head_ir_nx;
  logic [31:0]      head_npc_nx;
  logic             head_taken_nx;

  // FSM state register
  always_ff @(posedge clk1) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state: one idle cycle after reset, halt is sticky
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = RUN;
      RUN:     if (halt) state_nx = HALTED;
      HALTED:  state_nx = HALTED;
      default: state_nx = IDLE;
    endcase
  end

  // Redirects only matter while running; a halted core ignores them
  assign do_redirect = (state == RUN) && redirect;
  // Occupancy plus in-flight reads never exceeds DEPTH, so a push always fits
  assign imem_req    = (state == RUN) && !halt && !redirect &&
                       (({1'b0, count} + {1'b0, pend}) < CREDIT_MAX);
  assign imem_addr   = pc[ADDR_W-1:0];
  assign accept      = imem_req && imem_gnt;
  assign push        = imem_rvalid && (drop == '0) && !do_redirect;
  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready && !do_redirect;

  // Next occupancy and next head contents (registered outputs, no bypass)
  always_comb begin
    count_nx       = count;
    head_nx        = head;
    left_after_pop = count;
    head_ir_nx     = out_ir;
    head_npc_nx    = out_npc;
    head_taken_nx  = out_taken;
    if (pop) begin
      head_nx        = head + PTR_W'(1);
      left_after_pop = count - CNT_W'(1);
    end
    if (do_redirect)      count_nx = '0;
    else if (push && !pop) count_nx = count + CNT_W'(1);
    else if (!push && pop) count_nx = count - CNT_W'(1);
    if (!do_redirect && (count_nx != '0)) begin
      if (left_after_pop == '0) begin
        // queue drains to empty this cycle, so the new head is the pushed word
        head_ir_nx    = imem_rdata;
        head_npc_nx   = rsp_pc + 32'd1;
        head_taken_nx = mark_taken;
      end else begin
        head_ir_nx    = q_ir[head_nx];
        head_npc_nx   = q_npc[head_nx];
        head_taken_nx = q_taken[head_nx];
      end
    end
  end

  // Fetch PC, credit counters, stale-read tracking and head output registers
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      rsp_pc     <= RESET_PC;
      count      <= '0;
      pend       <= '0;
      drop       <= '0;
      head       <= '0;
      tail       <= '0;
      mark_taken <= 1'b0;
      out_ir     <= '0;
      out_npc    <= '0;
      out_taken  <= 1'b0;
    end else begin
      count     <= count_nx;
      head      <= do_redirect ? '0 : head_nx;
      out_ir    <= head_ir_nx;
      out_npc   <= head_npc_nx;
      out_taken <= head_taken_nx;
      if (do_redirect) begin
        pc         <= redirect_pc;
        rsp_pc     <= redirect_pc;
        mark_taken <= 1'b1;
        tail       <= '0;
        // everything still outstanding after this cycle belongs to the old path
        drop       <= imem_rvalid ? (pend - CNT_W'(1)) : pend;
      end else begin
        if (accept) pc <= pc + 32'd1;
        if (push) begin
          rsp_pc     <= rsp_pc + 32'd1;
          mark_taken <= 1'b0;
          tail       <= tail + PTR_W'(1);
        end
        if (imem_rvalid && (drop != '0)) drop <= drop - CNT_W'(1);
      end
      if (accept && !imem_rvalid)      pend <= pend + CNT_W'(1);
      else if (!accept && imem_rvalid) pend <= pend - CNT_W'(1);
    end
  end

  // Queue storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk1) begin
    if (push) begin
      q_ir[tail]    <= imem_rdata;
      q_npc[tail]   <= rsp_pc + 32'd1;
      q_taken[tail] <= mark_taken;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips32_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips32_fetch_queue
// Description : Directed bench for mips32_fetch_queue with an in-order,
//               fixed-latency instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips32_fetch_queue;

  logic        clk1        = 1'b0;
  logic        rst_n       = 1'b0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_gnt    = 1'b1;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halt        = 1'b0;
  logic        out_valid;
  logic [31:0] out_ir;
  logic [31:0] out_npc;
  logic        out_taken;
  logic        out_ready   = 1'b1;

  int tests   = 0;
  int fails   = 0;
  int edge_no = 0;
  int lat     = 1;
  int acc_cnt = 0;
  int mem_due;
  logic [9:0] acc_log [$];

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t rq [$];

  mips32_fetch_queue #(.ADDR_W(10), .DEPTH(4), .RESET_PC(32'd0)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .out_valid   (out_valid),
    .out_ir      (out_ir),
    .out_npc     (out_npc),
    .out_taken   (out_taken),
    .out_ready   (out_ready)
  );

  // 10 ns clock, posedges at 5, 15, 25 ...
  always #5 clk1 = ~clk1;

  // posedge counter used to schedule memory responses
  always @(posedge clk1) edge_no <= edge_no + 1;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  // Instruction memory: sampled 1 ns before each posedge, answers in order after lat cycles
  always @(negedge clk1) begin
    #4;
    if (!rst_n) begin
      rq.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
    end else begin
      if (imem_req && imem_gnt) begin
        mem_due = edge_no + 1 + lat;
        if (rq.size() > 0 && mem_due <= rq[$].due) mem_due = rq[$].due + 1;
        rq.push_back('{mem_word(imem_addr), mem_due});
        acc_cnt++;
        acc_log.push_back(imem_addr);
      end
      if (rq.size() > 0 && rq[0].due == edge_no + 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = rq[0].data;
        void'(rq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk1);
    #3;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // wait (bounded) for a head entry, check it, then advance one edge
  task automatic expect_head(input string tag, input logic [31:0] ir,
                             input logic [31:0] npc, input logic tk);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".ir"},    out_ir,         ir);
    check({tag, ".npc"},   out_npc,        npc);
    check({tag, ".taken"}, 32'(out_taken), 32'(tk));
    step();
  endtask

  task automatic do_reset(input int lat_i, input logic ready_i);
    rst_n     = 1'b0;
    redirect  = 1'b0;
    halt      = 1'b0;
    imem_gnt  = 1'b1;
    out_ready = ready_i;
    lat       = lat_i;
    step();
    step();
    check("reset.imem_req",  32'(imem_req),  32'd0);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_ir",    out_ir,         32'd0);
    check("reset.out_npc",   out_npc,        32'd0);
    check("reset.out_taken", 32'(out_taken), 32'd0);
    acc_cnt = 0;
    acc_log.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();

    // 1: streaming at latency 1
    do_reset(1, 1'b1);
    for (int i = 0; i < 6; i++)
      expect_head("t1", mem_word(10'(i)), 32'(i + 1), 1'b0);

    // 2: back-pressure, credit limit then in-order drain
    do_reset(1, 1'b0);
    repeat (10) step();
    check("t2.accepts",   32'(acc_cnt),   32'd4);
    check("t2.imem_req",  32'(imem_req),  32'd0);
    check("t2.out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      expect_head("t2", mem_word(10'(i)), 32'(i + 1), 1'b0);

    // 3: redirect with two stale reads in flight (latency 3)
    do_reset(3, 1'b1);
    step();
    step();
    step();
    check("t3.accepts", 32'(acc_cnt),  32'd2);
    check("t3.pend",    32'(dut.pend), 32'd2);
    redirect    = 1'b1;
    redirect_pc = 32'h20;
    #1;
    check("t3.req_in_redirect", 32'(imem_req), 32'd0);
    step();
    redirect = 1'b0;
    check("t3.drop",      32'(dut.drop),  32'd2);
    check("t3.out_valid", 32'(out_valid), 32'd0);
    expect_head("t3.first",  mem_word(10'h20), 32'h21, 1'b1);
    expect_head("t3.second", mem_word(10'h21), 32'h22, 1'b0);
    expect_head("t3.third",  mem_word(10'h22), 32'h23, 1'b0);

    // 4: redirect, ready and rvalid in the same cycle (latency 2)
    do_reset(2, 1'b0);
    repeat (4) step();
    check("t4.pre_valid", 32'(out_valid), 32'd1);
    check("t4.pre_ir",    out_ir,         mem_word(10'd0));
    check("t4.pre_count", 32'(dut.count), 32'd1);
    check("t4.pre_pend",  32'(dut.pend),  32'd2);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    out_ready   = 1'b1;
    step();
    redirect = 1'b0;
    check("t4.out_valid", 32'(out_valid), 32'd0);
    check("t4.drop",      32'(dut.drop),  32'd1);
    check("t4.pend",      32'(dut.pend),  32'd1);
    check("t4.hold_ir",   out_ir,         mem_word(10'd0));
    check("t4.hold_npc",  out_npc,        32'd1);
    expect_head("t4.first",  mem_word(10'h40), 32'h41, 1'b1);
    expect_head("t4.second", mem_word(10'h41), 32'h42, 1'b0);

    // 5: halt with three queued and one in flight
    do_reset(1, 1'b0);
    repeat (5) step();
    check("t5.accepts", 32'(acc_cnt),   32'd4);
    check("t5.count",   32'(dut.count), 32'd3);
    check("t5.pend",    32'(dut.pend),  32'd1);
    halt = 1'b1;
    #1;
    check("t5.req_halt", 32'(imem_req), 32'd0);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      expect_head("t5", mem_word(10'(i)), 32'(i + 1), 1'b0);
    repeat (3) step();
    check("t5.drained",  32'(out_valid), 32'd0);
    check("t5.no_fetch", 32'(acc_cnt),   32'd4);
    check("t5.req_idle", 32'(imem_req),  32'd0);
    check("t5.hold_ir",  out_ir,         mem_word(10'd3));
    check("t5.hold_npc", out_npc,        32'd4);
    halt        = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    repeat (4) step();
    check("t5.sticky_valid", 32'(out_valid), 32'd0);
    check("t5.sticky_req",   32'(imem_req),  32'd0);
    check("t5.sticky_acc",   32'(acc_cnt),   32'd4);

    // 6: redirect to the top of the 10-bit address space
    do_reset(1, 1'b1);
    expect_head("t6.pre0", mem_word(10'd0), 32'd1, 1'b0);
    expect_head("t6.pre1", mem_word(10'd1), 32'd2, 1'b0);
    redirect    = 1'b1;
    redirect_pc = 32'h3FF;
    acc_log.delete();
    step();
    redirect = 1'b0;
    expect_head("t6.top",  mem_word(10'h3FF), 32'h400, 1'b1);
    expect_head("t6.wrap", mem_word(10'h000), 32'h401, 1'b0);
    check("t6.log_size", 32'(acc_log.size() >= 2), 32'd1);
    if (acc_log.size() >= 2) begin
      check("t6.addr0", 32'(acc_log[0]), 32'h3FF);
      check("t6.addr1", 32'(acc_log[1]), 32'h000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
